// File: rtl/ctrl_encode_def.sv
// ---------------------------------------------------------------------------
// ctrl_encode_def
//   Shared definitions for the memory-port arbiter and its neighbours:
//     - 2-bit state encodings for the arbiter FSM and an enum built on them
//     - WORD_CTRL, the access-width code used for instruction fetches
//     - mem_cmd_t, the latched command presented to the shared memory port
//     - fetch_cmd(), builds the fixed-format command for a fetch
// ---------------------------------------------------------------------------
package ctrl_encode_def;

    // Arbiter state encodings.
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_SERV_DM = 2'd1;
    localparam logic [1:0] ST_SERV_IF = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

    typedef enum logic [1:0] {
        IDLE    = ST_IDLE,
        SERV_DM = ST_SERV_DM,
        SERV_IF = ST_SERV_IF,
        DONE    = ST_DONE
    } arb_state_t;

    // Full-word, unsigned access code; fetches always use it.
    localparam logic [2:0] WORD_CTRL = 3'b000;

    // Width of the wait-state counter; covers the largest legal TIMEOUT.
    localparam int CNT_W = 8;

    // Command captured at grant time and held on the memory port.
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        we;
        logic [2:0]  ctrl;
    } mem_cmd_t;

    // A fetch is always a word read.
    function automatic mem_cmd_t fetch_cmd(input logic [31:0] addr);
        mem_cmd_t cmd;
        cmd.addr  = addr;
        cmd.wdata = 32'h0000_0000;
        cmd.we    = 1'b0;
        cmd.ctrl  = WORD_CTRL;
        return cmd;
    endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//   Shares one memory port between instruction fetch (if_*) and the MEM-stage
//   data port (dm_*). The data port has fixed priority. A granted request is
//   latched, so the requester may change its inputs after the grant. A
//   transaction ends on mem_ack (ready pulse one cycle later, via DONE) or on
//   timeout (ready pulse with zero data, sticky err, straight back to IDLE).
//
//   Parameters
//     TIMEOUT   max SERV cycles waiting for mem_ack (2..255)
//   Ports
//     clk, reset                 clock, synchronous active-high reset
//     if_req/if_addr             fetch request and address
//     if_rdata/if_ready          fetched word, one-cycle completion pulse
//     dm_req/dm_we/dm_addr/
//     dm_wdata/dm_ctrl           data request, store flag, address, data, width
//     dm_rdata/dm_ready          load data, one-cycle completion pulse
//     mem_en/mem_we/mem_addr/
//     mem_wdata/mem_ctrl         shared memory command (valid while mem_en)
//     mem_rdata/mem_ack          memory read data and one-cycle completion
//     stall                      pipeline freeze while any request is open
//     err                        sticky timeout flag
// ---------------------------------------------------------------------------
module mem_port_arbiter
    import ctrl_encode_def::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ready,

    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    input  logic [2:0]  dm_ctrl,
    output logic [31:0] dm_rdata,
    output logic        dm_ready,

    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [2:0]  mem_ctrl,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,

    output logic        stall,
    output logic        err
);

    // Counter value at which the last allowed SERV cycle is reached.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    arb_state_t       state;
    mem_cmd_t         cmd;
    logic [CNT_W-1:0] wait_cnt;

    // The memory port always reflects the latched command; mem_en qualifies it.
    assign mem_addr  = cmd.addr;
    assign mem_wdata = cmd.wdata;
    assign mem_ctrl  = cmd.ctrl;

    // NOTE: stall is a plain continuous assignment of the inputs and the
    // registered ready pulses, so no storage can be inferred for it.
    assign stall = (dm_req && !dm_ready) || (if_req && !if_ready);

    // NOTE: every register below is assigned with <= so all of them update
    // together from the values present before the edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cmd      <= '0;
            wait_cnt <= '0;
            mem_en   <= 1'b0;
            mem_we   <= 1'b0;
            if_rdata <= 32'h0000_0000;
            dm_rdata <= 32'h0000_0000;
            if_ready <= 1'b0;
            dm_ready <= 1'b0;
            err      <= 1'b0;
        end else begin
            // Ready outputs are single-cycle pulses.
            if_ready <= 1'b0;
            dm_ready <= 1'b0;

            case (state)
                IDLE: begin
                    // A requester whose ready is high this cycle (timeout exit)
                    // is still holding req for that cycle; it is not a new
                    // request and must not be granted again.
                    if (dm_req && !dm_ready) begin
                        cmd.addr  <= dm_addr;
                        cmd.wdata <= dm_wdata;
                        cmd.we    <= dm_we;
                        cmd.ctrl  <= dm_ctrl;
                        mem_en    <= 1'b1;
                        mem_we    <= dm_we;
                        wait_cnt  <= '0;
                        state     <= SERV_DM;
                    end else if (if_req && !if_ready) begin
                        cmd      <= fetch_cmd(if_addr);
                        mem_en   <= 1'b1;
                        mem_we   <= 1'b0;
                        wait_cnt <= '0;
                        state    <= SERV_IF;
                    end
                end

                SERV_DM, SERV_IF: begin
                    if (mem_ack) begin
                        mem_en <= 1'b0;
                        mem_we <= 1'b0;
                        if (state == SERV_DM) begin
                            dm_rdata <= mem_rdata;
                            dm_ready <= 1'b1;
                        end else begin
                            if_rdata <= mem_rdata;
                            if_ready <= 1'b1;
                        end
                        state <= DONE;
                    end else if (wait_cnt == CNT_LAST) begin
                        // Give up: complete the requester with zero data so
                        // the pipeline can move on, and remember the fault.
                        mem_en <= 1'b0;
                        mem_we <= 1'b0;
                        err    <= 1'b1;
                        if (state == SERV_DM) begin
                            dm_rdata <= 32'h0000_0000;
                            dm_ready <= 1'b1;
                        end else begin
                            if_rdata <= 32'h0000_0000;
                            if_ready <= 1'b1;
                        end
                        state <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end

                // The ready pulse is out this cycle; the requester's req is
                // still high, so re-arbitration waits for IDLE.
                DONE: state <= IDLE;

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
//   Directed bench for mem_port_arbiter. Expected completions are queued when
//   a request is driven and popped by a negedge monitor when a ready pulse
//   appears. A second instance with TIMEOUT = 4 covers the timeout path.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;
    import ctrl_encode_def::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        hold_t;
    logic        reset_t;

    logic        if_req;
    logic [31:0] if_addr;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [2:0]  dm_ctrl;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    logic [31:0] if_rdata,  dm_rdata;
    logic        if_ready,  dm_ready;
    logic        mem_en,    mem_we;
    logic [31:0] mem_addr,  mem_wdata;
    logic [2:0]  mem_ctrl;
    logic        stall,     err;

    logic [31:0] if_rdata_t, dm_rdata_t;
    logic        if_ready_t, dm_ready_t;
    logic        mem_en_t,   mem_we_t;
    logic [31:0] mem_addr_t, mem_wdata_t;
    logic [2:0]  mem_ctrl_t;
    logic        stall_t,    err_t;

    always #5 clk = ~clk;

    assign reset_t = reset | hold_t;

    mem_port_arbiter dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_ctrl(dm_ctrl), .dm_rdata(dm_rdata), .dm_ready(dm_ready),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ctrl(mem_ctrl), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .stall(stall), .err(err)
    );

    mem_port_arbiter #(.TIMEOUT(4)) dut_t4 (
        .clk(clk), .reset(reset_t),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata_t), .if_ready(if_ready_t),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_ctrl(dm_ctrl), .dm_rdata(dm_rdata_t), .dm_ready(dm_ready_t),
        .mem_en(mem_en_t), .mem_we(mem_we_t), .mem_addr(mem_addr_t), .mem_wdata(mem_wdata_t),
        .mem_ctrl(mem_ctrl_t), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .stall(stall_t), .err(err_t)
    );

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_pass   = 0;

    typedef struct packed {
        logic        is_dm;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   dm_ready_cnt = 0;
    int   if_ready_cnt = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    endtask

    task automatic push_exp(input logic is_dm, input logic [31:0] data);
        exp_t e;
        e.is_dm = is_dm;
        e.data  = data;
        exp_q.push_back(e);
    endtask

    // Scoreboard: each ready pulse of the main instance must match the head.
    always @(negedge clk) begin
        exp_t e;
        if (dm_ready === 1'b1) begin
            dm_ready_cnt++;
            if (exp_q.size() != 0 && exp_q[0].is_dm) begin
                e = exp_q.pop_front();
                check("sb_dm_rdata", dm_rdata, e.data);
            end else begin
                check("sb_dm_ready_unexpected", dm_ready, 1'b0);
            end
        end
        if (if_ready === 1'b1) begin
            if_ready_cnt++;
            if (exp_q.size() != 0 && !exp_q[0].is_dm) begin
                e = exp_q.pop_front();
                check("sb_if_rdata", if_rdata, e.data);
            end else begin
                check("sb_if_ready_unexpected", if_ready, 1'b0);
            end
        end
    end

    // ---------------- memory-side responder ----------------
    int          waited;
    int          stable_cyc;
    logic [31:0] cap_addr, cap_wdata;
    logic        cap_we;
    logic [2:0]  cap_ctrl;

    // Waits (bounded) for mem_en, captures the command, holds the memory
    // for 'delay' extra cycles and then acks. Returns at the ready negedge.
    task automatic do_serve(input int delay, input logic [31:0] rd, input bit scramble);
        waited = 0;
        while (mem_en !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (mem_en !== 1'b1) begin
            check("grant_wait_expired", mem_en, 1'b1);
            return;
        end
        cap_addr   = mem_addr;
        cap_wdata  = mem_wdata;
        cap_we     = mem_we;
        cap_ctrl   = mem_ctrl;
        stable_cyc = 0;
        if (scramble) begin
            dm_addr  = ~dm_addr;
            dm_wdata = ~dm_wdata;
            dm_ctrl  = ~dm_ctrl;
        end
        for (int i = 0; i <= delay; i++) begin
            if (mem_en === 1'b1 && mem_addr === cap_addr && mem_wdata === cap_wdata &&
                mem_we === cap_we && mem_ctrl === cap_ctrl)
                stable_cyc++;
            check("stall_while_serving", stall, 1'b1);
            if (i == delay) begin
                mem_ack   = 1'b1;
                mem_rdata = rd;
            end
            @(negedge clk);
        end
        mem_ack   = 1'b0;
        mem_rdata = 32'hBAD0_BAD0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int cnt0;
        int serv_t;
        int k;

        reset = 1'b1; hold_t = 1'b1;
        if_req = 1'b0; if_addr = '0;
        dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0; dm_ctrl = '0;
        mem_rdata = '0; mem_ack = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_mem_en",   mem_en,   1'b0);
        check("rst_mem_we",   mem_we,   1'b0);
        check("rst_if_ready", if_ready, 1'b0);
        check("rst_dm_ready", dm_ready, 1'b0);
        check("rst_err",      err,      1'b0);
        check("rst_if_rdata", if_rdata, 32'h0);
        check("rst_dm_rdata", dm_rdata, 32'h0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_stall",    stall,    1'b0);
        reset = 1'b0;
        @(negedge clk);
        check("idle_mem_en", mem_en, 1'b0);

        // Single fetch at minimum latency
        if_req = 1'b1; if_addr = 32'h0000_0040;
        push_exp(1'b0, 32'h0010_0093);
        #1 check("fetch_stall_req", stall, 1'b1);
        do_serve(0, 32'h0010_0093, 1'b0);
        check("fetch_latency",  waited,     1);
        check("fetch_addr",     cap_addr,   32'h0000_0040);
        check("fetch_we",       cap_we,     1'b0);
        check("fetch_ctrl",     cap_ctrl,   WORD_CTRL);
        check("fetch_ready",    if_ready,   1'b1);
        check("fetch_rdata",    if_rdata,   32'h0010_0093);
        check("fetch_stall_rdy", stall,     1'b0);
        if_req = 1'b0;
        @(negedge clk);
        check("fetch_ready_one", if_ready,  1'b0);
        check("fetch_en_off",    mem_en,    1'b0);
        check("fetch_rdata_hold", if_rdata, 32'h0010_0093);

        // Simultaneous store and fetch: store first
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h0000_0100;
        dm_wdata = 32'hDEAD_BEEF; dm_ctrl = 3'b010;
        if_req = 1'b1; if_addr = 32'h0000_0044;
        push_exp(1'b1, 32'h1111_1111);
        push_exp(1'b0, 32'h0000_0013);
        do_serve(0, 32'h1111_1111, 1'b0);
        check("sim_store_we",    cap_we,    1'b1);
        check("sim_store_addr",  cap_addr,  32'h0000_0100);
        check("sim_store_wdata", cap_wdata, 32'hDEAD_BEEF);
        check("sim_store_ctrl",  cap_ctrl,  3'b010);
        check("sim_dm_ready",    dm_ready,  1'b1);
        check("sim_stall_done",  stall,     1'b1);
        dm_req = 1'b0; dm_we = 1'b0;
        @(negedge clk);
        check("sim_stall_idle",  stall,     1'b1);
        do_serve(0, 32'h0000_0013, 1'b0);
        check("sim_fetch_gap",   waited,    1);
        check("sim_fetch_addr",  cap_addr,  32'h0000_0044);
        check("sim_fetch_we",    cap_we,    1'b0);
        check("sim_fetch_ctrl",  cap_ctrl,  WORD_CTRL);
        if_req = 1'b0;
        check("sim_dm_rdata_hold", dm_rdata, 32'h1111_1111);
        @(negedge clk);

        // Wait states: ack five cycles late, requester scrambles inputs
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h0000_0200;
        dm_wdata = 32'h0BAD_F00D; dm_ctrl = 3'b100;
        push_exp(1'b1, 32'hCAFE_0001);
        cnt0 = dm_ready_cnt;
        do_serve(5, 32'hCAFE_0001, 1'b1);
        check("ws_stable_cycles", stable_cyc, 6);
        check("ws_addr",          cap_addr,   32'h0000_0200);
        check("ws_wdata",         cap_wdata,  32'h0BAD_F00D);
        dm_req = 1'b0;
        repeat (3) @(negedge clk);
        check("ws_ready_once", dm_ready_cnt - cnt0, 1);

        // Back-to-back loads with a fetch pending
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h0000_0300; dm_ctrl = 3'b010;
        if_req = 1'b1; if_addr = 32'h0000_0048;
        push_exp(1'b1, 32'h0000_000A);
        push_exp(1'b1, 32'h0000_000B);
        push_exp(1'b0, 32'h0000_0073);
        do_serve(0, 32'h0000_000A, 1'b0);
        check("b2b_first_addr", cap_addr, 32'h0000_0300);
        dm_addr = 32'h0000_0304;
        do_serve(0, 32'h0000_000B, 1'b0);
        check("b2b_idle_between", waited,  2);
        check("b2b_second_addr",  cap_addr, 32'h0000_0304);
        check("b2b_second_we",    cap_we,   1'b0);
        dm_req = 1'b0;
        do_serve(0, 32'h0000_0073, 1'b0);
        check("b2b_fetch_addr",   cap_addr, 32'h0000_0048);
        check("b2b_fetch_we",     cap_we,   1'b0);
        if_req = 1'b0;
        @(negedge clk);

        // Timeout on the TIMEOUT = 4 instance
        reset = 1'b1; hold_t = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("to_err_clear", err_t, 1'b0);
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h0000_0400;
        push_exp(1'b1, 32'h5555_AAAA);
        do_serve(0, 32'h5555_AAAA, 1'b0);
        check("to_pre_ready", dm_ready_t, 1'b1);
        check("to_pre_rdata", dm_rdata_t, 32'h5555_AAAA);
        dm_req = 1'b0;
        @(negedge clk);
        dm_req = 1'b1; dm_addr = 32'h0000_0404;
        serv_t = 0; k = 0;
        while (dm_ready_t !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
            if (mem_en_t === 1'b1) serv_t++;
        end
        check("to_ready",       dm_ready_t, 1'b1);
        check("to_serv_cycles", serv_t,     4);
        check("to_rdata_zero",  dm_rdata_t, 32'h0);
        check("to_err_set",     err_t,      1'b1);
        check("to_main_no_err", err,        1'b0);
        // Late ack: completes the main instance, ignored by the idle one.
        dm_req = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h0000_0077;
        push_exp(1'b1, 32'h0000_0077);
        @(negedge clk);
        mem_ack = 1'b0;
        check("to_main_ready",     dm_ready,   1'b1);
        check("to_idle_ack_ready", dm_ready_t, 1'b0);
        check("to_idle_ack_rdata", dm_rdata_t, 32'h0);
        check("to_idle_ack_en",    mem_en_t,   1'b0);
        repeat (3) @(negedge clk);
        check("to_err_sticky", err_t, 1'b1);

        // Reset in the middle of a store, then a late ack
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h0000_0500; dm_wdata = 32'h1234_5678;
        k = 0;
        while (mem_en !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("mr_granted", mem_en, 1'b1);
        cnt0 = dm_ready_cnt;
        reset = 1'b1;
        @(negedge clk);
        check("mr_en_off",   mem_en,    1'b0);
        check("mr_we_off",   mem_we,    1'b0);
        check("mr_addr_clr", mem_addr,  32'h0);
        check("mr_wdat_clr", mem_wdata, 32'h0);
        check("mr_err_t_clr", err_t,    1'b0);
        reset = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
        mem_ack = 1'b1; mem_rdata = 32'h0000_0099;
        @(negedge clk);
        mem_ack = 1'b0;
        check("mr_no_ready",  dm_ready, 1'b0);
        check("mr_rdata_clr", dm_rdata, 32'h0);
        check("mr_en_idle",   mem_en,   1'b0);
        @(negedge clk);
        check("mr_no_ready_later", dm_ready_cnt - cnt0, 0);
        check("mr_stall_idle",     stall,               1'b0);

        check("sb_queue_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
